// File: rtl/mult_seq.sv
// mult_seq: iterative radix-2 shift-add 32x32 multiplier with sign correction, {hi,lo} result in z.
// Define MULT_MADD_EN to honour acc (z <= z + product); otherwise acc is ignored.
module mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 isSigned,
    input  logic                 acc,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   z
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 neg;
    logic                 acc_q;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   z_next;
    assign product = neg ? -prod : prod;
`ifdef MULT_MADD_EN
    assign z_next = acc_q ? z + product : product;
`else
    logic unused_acc;
    assign unused_acc = acc_q;
    assign z_next = product;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            prod   <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            acc_q  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            z      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    // signed operands run on magnitudes; |-2^(W-1)| still fits W unsigned bits
                    mcand  <= {{WIDTH{1'b0}}, (isSigned && a[WIDTH-1]) ? -a : a};
                    mplier <= (isSigned && b[WIDTH-1]) ? -b : b;
                    neg    <= isSigned && (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_q  <= acc;
                    prod   <= '0;
                    cnt    <= '0;
                    busy   <= 1'b1;
                    state  <= RUN;
                end
                RUN: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    z     <= z_next;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed vectors for mult_seq, checked every cycle against an arithmetic reference model.
module tb_mult_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        isSigned = 1'b0;
    logic        acc = 1'b0;
    logic        busy;
    logic        done;
    logic [63:0] z;
    int compared = 0;
    int mismatched = 0;
`ifdef MULT_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif
    mult_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .isSigned(isSigned), .acc(acc), .busy(busy), .done(done), .z(z)
    );
    always #5 clk = ~clk;
    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic signed [63:0] sx, sy;
        sx = $signed(x);
        sy = $signed(y);
        return s ? 64'(sx * sy) : {32'd0, x} * {32'd0, y};
    endfunction
    // reference: an accepted start yields its result 33 edges later
    int          m_left = 0;
    logic [63:0] m_z = '0;
    logic [63:0] m_pend = '0;
    logic        m_acc = 1'b0;
    logic        m_done = 1'b0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_z    <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= (m_left == 1);
            if (m_left == 1) m_z <= m_acc ? m_z + m_pend : m_pend;
            if (m_left > 0) m_left <= m_left - 1;
            else if (start) begin
                m_pend <= ref_mul(a, b, isSigned);
                m_acc  <= acc && MADD;
                m_left <= 33;
            end
        end
    end
    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask
    always @(negedge clk) begin
        check("busy", 64'(busy), 64'(m_left != 0));
        check("done", 64'(done), 64'(m_done));
        check("z", z, m_z);
    end
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s, input logic k,
                          input logic [63:0] exp_z, input string nm);
        int n;
        @(posedge clk); #1;
        a = x; b = y; isSigned = s; acc = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'd33);
        check({nm, "_z"}, z, exp_z);
    endtask
    initial begin
        int dones;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_z", z, 64'd0);
        rst_n = 1'b1;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFE00000001, "unsigned_max");
        run_op(32'hFFFFFFFD, 32'd7, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFEB, "signed_mixed");
        run_op(32'hFFFFFFFD, 32'd7, 1'b0, 1'b0, 64'h00000006FFFFFFEB, "unsigned_mixed");
        run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 64'h4000000000000000, "signed_extreme");
        run_op(32'd7, 32'hFFFFFFFB, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFDD, "signed_pos_neg");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 64'd1, "signed_neg_neg");
        // a start arriving mid-run must be dropped
        @(posedge clk); #1;
        a = 32'd5; b = 32'd6; isSigned = 1'b0; acc = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dones = 0;
        repeat (65) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("busy_reject_dones", 64'(dones), 64'd1);
        check("busy_reject_z", z, 64'h1E);
        // reset in the middle of a run
        @(posedge clk); #1;
        a = 32'h1234; b = 32'h10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_z", z, 64'd0);
        dones = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        check("midreset_no_done", 64'(dones), 64'd0);
        run_op(32'd2, 32'd3, 1'b0, 1'b0, 64'd6, "after_reset");
        run_op(32'd1, 32'd5, 1'b0, 1'b0, 64'd5, "acc_seed");
        run_op(32'd2, 32'd3, 1'b0, 1'b1, MADD ? 64'h0B : 64'h06, "accumulate");
        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, compared %0d mismatched %0d", compared, mismatched);
        $fatal(1, "timeout");
    end
endmodule
